loop_monitor: RTL

- Synchronous observer directly downstream of the combinational feedback-loop stage (`a`, `b`, `c`, `y`).
- Synchronizes the four loop outputs into the `clk` domain and detects edges on `y`.
- Reports whether `y` has settled or is oscillating.
- Counts `y` transitions over a fixed measurement window, so the loop's behaviour can be observed, logged and checked on-board.

---
 rtl/loop_monitor_pkg.sv | 11 +
 rtl/bit_synchronizer.sv | 27 ++
 rtl/loop_monitor.sv | 108 ++++++++++
 3 files changed

// File: rtl/loop_monitor_pkg.sv
// Shared types and default parameters for the feedback-loop observer.
package loop_monitor_pkg;

    typedef enum logic [1:0] {IDLE, MEASURE, DONE} lm_state_t;

    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned DEF_WINDOW        = 256;
    localparam int unsigned DEF_STABLE_CYCLES = 8;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-stage flop synchronizer for asynchronous level inputs; synchronous active-low reset.
module bit_synchronizer
    import loop_monitor_pkg::*;
#(
    parameter int unsigned STAGES = DEF_SYNC_STAGES,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/loop_monitor.sv
// Observer for the combinational loop stage: synchronizes a/b/c/y, detects y edges,
// flags stability and counts y transitions over a start-armed measurement window.
module loop_monitor
    import loop_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned WINDOW        = DEF_WINDOW,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             y,
    input  logic             start,
    output logic [2:0]       abc_sync,
    output logic             y_sync,
    output logic             y_rise,
    output logic [CNT_W-1:0] toggle_count,
    output logic             count_valid,
    output logic             busy,
    output logic             stable,
    output logic             oscillating
);

    localparam int unsigned WIN_W = $clog2(WINDOW);
    localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [3:0]       sync_q;
    logic             y_d;
    logic             y_evt;
    lm_state_t        state;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_cnt_next;
    logic [WIN_W-1:0] win_cnt;
    logic [STB_W-1:0] stb_cnt;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (4)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({a, b, c, y}),
        .q     (sync_q)
    );

    assign abc_sync = sync_q[3:1];
    assign y_sync   = sync_q[0];
    assign y_rise   = y_sync & ~y_d;
    assign y_evt    = y_sync ^ y_d;
    assign busy     = (state == MEASURE);
    assign stable   = (stb_cnt == STB_MAX);

    // Saturating increment; also feeds toggle_count so the last MEASURE cycle's event is included.
    assign edge_cnt_next = (y_evt && edge_cnt != CNT_MAX) ? edge_cnt + 1'b1 : edge_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            y_d     <= 1'b0;
            stb_cnt <= '0;
        end else begin
            y_d <= y_sync;
            if (y_evt)                stb_cnt <= '0;
            else if (stb_cnt != STB_MAX) stb_cnt <= stb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            win_cnt      <= '0;
            toggle_count <= '0;
            count_valid  <= 1'b0;
            oscillating  <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= MEASURE;
                        edge_cnt <= '0;
                        win_cnt  <= '0;
                    end
                end
                MEASURE: begin
                    edge_cnt <= edge_cnt_next;
                    if (win_cnt == WIN_LAST) begin
                        state        <= DONE;
                        toggle_count <= edge_cnt_next;
                        count_valid  <= 1'b1;
                        oscillating  <= (edge_cnt_next >= CNT_W'(2));
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
